// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: captures GRF/DM commit events in program order into a
// DEPTH-entry FIFO drained over a valid/ready stream, with sticky overflow.
module commit_trace_buffer #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     grf_we,
    input  logic [31:0]              grf_pc,
    input  logic [4:0]               grf_addr,
    input  logic [31:0]              grf_data,
    input  logic                     dm_we,
    input  logic [31:0]              dm_pc,
    input  logic [31:0]              dm_addr,
    input  logic [31:0]              dm_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_kind,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_addr,
    output logic [31:0]              out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          g_ent, d_ent, head;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, d_ptr;
    logic [LW-1:0]   level_q, level_d, free;
    logic            overflow_q, overflow_d;
    logic            deq, g_ev, d_ev, g_acc, d_acc;

    always_comb begin
        deq        = (level_q != '0) && out_ready;
        free       = LW'(DEPTH) - level_q + LW'(deq);
        g_ev       = grf_we && (grf_addr != 5'd0);
        d_ev       = dm_we;
        // GRF claims the first free slot; DM needs one beyond whatever GRF took
        g_acc      = g_ev && (free != '0);
        d_acc      = d_ev && (free > LW'(g_acc));
        g_ent      = {1'b0, grf_pc, {27'b0, grf_addr}, grf_data};
        d_ent      = {1'b1, dm_pc, dm_addr, dm_data};
        d_ptr      = wr_ptr_q + AW'(g_acc);
        wr_ptr_d   = wr_ptr_q + AW'(g_acc) + AW'(d_acc);
        rd_ptr_d   = rd_ptr_q + AW'(deq);
        level_d    = level_q + LW'(g_acc) + LW'(d_acc) - LW'(deq);
        overflow_d = overflow_q | (g_ev & ~g_acc) | (d_ev & ~d_acc);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (g_acc) mem_q[wr_ptr_q] <= g_ent;
        if (d_acc) mem_q[d_ptr] <= d_ent;
    end

    assign head      = mem_q[rd_ptr_q];
    assign out_valid = (level_q != '0);
    assign out_kind  = head.kind;
    assign out_pc    = head.pc;
    assign out_addr  = head.addr;
    assign out_data  = head.data;
    assign level     = level_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: directed scenarios plus random traffic checked
// against a queue-based model of the commit trace FIFO.
module tb_commit_trace_buffer;
    localparam int DEPTH = 8;
    localparam int LW = $clog2(DEPTH) + 1;

    logic          clk, reset;
    logic          grf_we, dm_we, out_ready;
    logic [31:0]   grf_pc, grf_data, dm_pc, dm_addr, dm_data;
    logic [4:0]    grf_addr;
    logic          out_valid, out_kind, overflow;
    logic [31:0]   out_pc, out_addr, out_data;
    logic [LW-1:0] level;

    typedef struct {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t q[$];
    bit  ovf_m;
    int  n_vec, n_err;

    commit_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_data(grf_data),
        .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_data(dm_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
        .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data),
        .level(level), .overflow(overflow)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".valid"}, 64'(out_valid), 64'(q.size() != 0));
        chk({tag, ".level"}, 64'(level), 64'(q.size()));
        chk({tag, ".overflow"}, 64'(overflow), 64'(ovf_m));
        if (q.size() != 0) begin
            chk({tag, ".kind"}, 64'(out_kind), 64'(q[0].kind));
            chk({tag, ".pc"}, 64'(out_pc), 64'(q[0].pc));
            chk({tag, ".addr"}, 64'(out_addr), 64'(q[0].addr));
            chk({tag, ".data"}, 64'(out_data), 64'(q[0].data));
        end
    endtask

    // Called just after a rising edge: drive, check pre-edge view, advance model.
    task automatic cycle(input bit gwe, input logic [4:0] ga, input logic [31:0] gpc, input logic [31:0] gd,
                         input bit dwe, input logic [31:0] dpc, input logic [31:0] da, input logic [31:0] dd,
                         input bit rdy, input string tag);
        int free;
        bit deq;
        grf_we = gwe; grf_addr = ga; grf_pc = gpc; grf_data = gd;
        dm_we = dwe; dm_pc = dpc; dm_addr = da; dm_data = dd;
        out_ready = rdy;
        @(negedge clk);
        check_outs(tag);
        deq  = (q.size() != 0) && rdy;
        free = DEPTH - q.size() + int'(deq);
        if (deq) void'(q.pop_front());
        if (gwe && ga != 0) begin
            if (free > 0) begin
                q.push_back('{1'b0, gpc, {27'b0, ga}, gd});
                free--;
            end else ovf_m = 1;
        end
        if (dwe) begin
            if (free > 0) q.push_back('{1'b1, dpc, da, dd});
            else ovf_m = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy, input string tag);
        cycle(0, 5'd0, 0, 0, 0, 0, 0, 0, rdy, tag);
    endtask

    task automatic do_reset();
        reset = 0;
        #1;
        q.delete();
        ovf_m = 0;
        @(posedge clk);
        #1;
        reset = 1;
    endtask

    initial begin
        n_vec = 0; n_err = 0; ovf_m = 0;
        grf_we = 0; grf_addr = 0; grf_pc = 0; grf_data = 0;
        dm_we = 0; dm_pc = 0; dm_addr = 0; dm_data = 0; out_ready = 0;
        reset = 0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset");
        reset = 1;

        // single GRF event, visible only after the edge
        cycle(1, 5'd5, 32'h3000, 32'h1234, 0, 0, 0, 0, 0, "single_grf");
        idle(0, "single_grf_hold");
        idle(1, "single_grf_pop");
        idle(0, "empty_after_pop");

        // dual event: GRF ahead of DM
        cycle(1, 5'd8, 32'h100, 32'hA, 1, 32'h104, 32'h10, 32'hB, 0, "dual");
        idle(1, "dual_pop_grf");
        idle(1, "dual_pop_dm");
        idle(1, "dual_empty_ready");

        // register 0 writes are filtered
        cycle(1, 5'd0, 32'h200, 32'hDEAD, 0, 0, 0, 0, 1, "r0_filter");
        idle(0, "r0_filter_after");
        chk("r0_level", 64'(level), 64'd0);

        // overflow: 7 GRF then dual, DM dropped
        for (int i = 0; i < 7; i++)
            cycle(1, 5'(i + 1), 32'h400 + 32'(4 * i), 32'(i), 0, 0, 0, 0, 0, "fill");
        cycle(1, 5'd20, 32'h41C, 32'h77, 1, 32'h420, 32'h80, 32'h88, 0, "fill_dual");
        idle(0, "full_check");
        chk("full_level", 64'(level), 64'(DEPTH));
        chk("full_overflow", 64'(overflow), 64'd1);
        cycle(1, 5'd3, 32'h500, 32'h1, 1, 32'h504, 32'h8, 32'h2, 0, "full_drop");

        // full with simultaneous pop accepts a DM event
        cycle(0, 5'd0, 0, 0, 1, 32'h600, 32'h40, 32'h99, 1, "full_pop_dm");
        idle(0, "full_pop_dm_after");
        chk("full_pop_level", 64'(level), 64'(DEPTH));
        for (int i = 0; i < DEPTH; i++) idle(1, "drain");
        idle(0, "drained");
        chk("drained_overflow", 64'(overflow), 64'd1);

        // asynchronous reset mid-stream
        do_reset();
        for (int i = 0; i < 5; i++)
            cycle(1, 5'(i + 10), 32'h700 + 32'(i), 32'(i * 3), 0, 0, 0, 0, 0, "pre_rst");
        cycle(0, 5'd0, 0, 0, 1, 32'h800, 32'h4, 32'h5, 0, "pre_rst_dm");
        grf_we = 0; dm_we = 0;
        #2;
        reset = 0;
        #1;
        chk("async_rst_level", 64'(level), 64'd0);
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_overflow", 64'(overflow), 64'd0);
        q.delete();
        ovf_m = 0;
        @(posedge clk);
        #3;
        reset = 1;
        @(posedge clk);
        #1;
        cycle(1, 5'd31, 32'h900, 32'hCAFE, 0, 0, 0, 0, 0, "post_rst");
        idle(0, "post_rst_sole");
        chk("post_rst_level", 64'(level), 64'd1);
        idle(1, "post_rst_pop");

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if (i == 750) do_reset();
            cycle($urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom, $urandom,
                  $urandom_range(0, 2) == 0, $urandom, $urandom, $urandom,
                  $urandom_range(0, 3) < ((i / 200) % 2 == 0 ? 1 : 3), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
